vx_tag_assoc: RTL and testbench

- Per-bank N-way set-associative tag store; next generation of the bank's direct-mapped tag lookup.
- Adds per-way valid and dirty bits, round-robin victim selection with invalid-way preference, and a one-cycle registered lookup response.
- Adds a sequencer that clears all sets after reset and walks every line on a flush request, reporting dirty evictions.
- Sits between the bank's request arbiter and its data-store/MSHR logic.

---
 rtl/vx_tag_pkg.sv | 30 +++
 rtl/vx_tag_assoc_if.sv | 29 ++
 rtl/vx_tag_victim_sel.sv | 22 ++
 rtl/vx_tag_assoc.sv | 169 ++++++++++++++++
 tb/tb_vx_tag_assoc.sv | 372 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/vx_tag_pkg.sv
// Shared constants and types for the set-associative bank tag store.
package vx_tag_pkg;

  localparam int CACHE_SIZE      = 16384;
  localparam int CACHE_LINE_SIZE = 64;
  localparam int NUM_BANKS       = 4;
  localparam int NUM_WAYS        = 4;
  localparam int LINE_ADDR_WIDTH = 26;

  localparam int LINES_PER_BANK  = CACHE_SIZE / (CACHE_LINE_SIZE * NUM_BANKS);
  localparam int NUM_SETS        = LINES_PER_BANK / NUM_WAYS;
  localparam int SET_BITS        = $clog2(NUM_SETS);
  localparam int TAG_BITS        = LINE_ADDR_WIDTH - SET_BITS;
  localparam int WAY_BITS        = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int WAY_SHIFT       = $clog2(NUM_WAYS);
  localparam int LINE_BITS       = $clog2(LINES_PER_BANK);

  typedef enum logic [1:0] {
    S_INIT  = 2'd0,
    S_IDLE  = 2'd1,
    S_FLUSH = 2'd2
  } tag_state_e;

  typedef struct packed {
    logic                valid;
    logic                dirty;
    logic [TAG_BITS-1:0] tag;
  } tag_entry_t;

endpackage

// File: rtl/vx_tag_assoc_if.sv
// Request/response bundle between the bank arbiter and the tag store.
interface vx_tag_assoc_if;
  import vx_tag_pkg::*;

  logic                       stall;
  logic                       lookup;
  logic                       write;
  logic                       fill;
  logic [LINE_ADDR_WIDTH-1:0] addr;
  logic                       flush_req;
  logic                       ready;
  logic                       rsp_valid;
  logic                       tag_match;
  logic [WAY_BITS-1:0]        hit_way;
  logic                       evict_valid;
  logic [LINE_ADDR_WIDTH-1:0] evict_addr;
  logic                       flush_done;

  modport master (
    output stall, lookup, write, fill, addr, flush_req,
    input  ready, rsp_valid, tag_match, hit_way, evict_valid, evict_addr, flush_done
  );

  modport slave (
    input  stall, lookup, write, fill, addr, flush_req,
    output ready, rsp_valid, tag_match, hit_way, evict_valid, evict_addr, flush_done
  );

endinterface

// File: rtl/vx_tag_victim_sel.sv
// Victim picker for one set: lowest invalid way wins, else the round-robin pointer.
module vx_tag_victim_sel
  import vx_tag_pkg::*;
(
  input  logic [NUM_WAYS-1:0] valid,
  input  logic [WAY_BITS-1:0] ptr,
  output logic [WAY_BITS-1:0] victim,
  output logic                use_ptr
);

  always_comb begin
    victim  = ptr;
    use_ptr = 1'b1;
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (!valid[w]) begin
        victim  = WAY_BITS'(w);
        use_ptr = 1'b0;
      end
    end
  end

endmodule

// File: rtl/vx_tag_assoc.sv
// N-way set-associative bank tag store with registered lookup/fill response,
// post-reset clearing walk and a flush walk that reports dirty lines.
module vx_tag_assoc
  import vx_tag_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  vx_tag_assoc_if.slave bus
);

  localparam logic [1:0] ST_INIT  = S_INIT;
  localparam logic [1:0] ST_IDLE  = S_IDLE;
  localparam logic [1:0] ST_FLUSH = S_FLUSH;

  tag_entry_t           entries [NUM_SETS][NUM_WAYS];
  logic [WAY_BITS-1:0]  rr_ptr  [NUM_SETS];

  logic [1:0]           state;
  logic [LINE_BITS-1:0] cnt;

  logic                       rsp_valid_p0;
  logic                       tag_match_p0;
  logic [WAY_BITS-1:0]        hit_way_p0;
  logic                       evict_valid_p0;
  logic [LINE_ADDR_WIDTH-1:0] evict_addr_p0;
  logic                       flush_done_p0;

  logic [SET_BITS-1:0]  req_set;
  logic [TAG_BITS-1:0]  req_tag;
  logic [NUM_WAYS-1:0]  way_valid;
  logic [NUM_WAYS-1:0]  way_match;
  logic                 lk_hit;
  logic [WAY_BITS-1:0]  lk_way;
  logic [WAY_BITS-1:0]  vic_way;
  logic                 vic_use_ptr;
  tag_entry_t           vic_entry;
  logic [SET_BITS-1:0]  fl_set;
  logic [WAY_BITS-1:0]  fl_way;
  tag_entry_t           fl_entry;
  logic [SET_BITS-1:0]  init_set;
  logic                 accept_idle;

  assign req_set  = bus.addr[SET_BITS-1:0];
  assign req_tag  = bus.addr[LINE_ADDR_WIDTH-1:SET_BITS];
  assign init_set = SET_BITS'(cnt);
  assign fl_set   = SET_BITS'(cnt >> WAY_SHIFT);
  assign fl_way   = WAY_BITS'(cnt % NUM_WAYS);
  assign fl_entry = entries[fl_set][fl_way];

  // A same-cycle flush request swallows any lookup/fill.
  assign accept_idle = (state == ST_IDLE) && !bus.stall && !bus.flush_req;

  always_comb begin
    lk_hit = 1'b0;
    lk_way = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      way_valid[w] = entries[req_set][w].valid;
      way_match[w] = entries[req_set][w].valid && (entries[req_set][w].tag == req_tag);
    end
    for (int w = NUM_WAYS - 1; w >= 0; w--) begin
      if (way_match[w]) begin
        lk_hit = 1'b1;
        lk_way = WAY_BITS'(w);
      end
    end
  end

  vx_tag_victim_sel u_victim_sel (
    .valid   (way_valid),
    .ptr     (rr_ptr[req_set]),
    .victim  (vic_way),
    .use_ptr (vic_use_ptr)
  );

  assign vic_entry = entries[req_set][vic_way];

  // Stage p0: control, walk counter and registered response
  always_ff @(posedge clk) begin
    if (!reset) begin
      state          <= ST_INIT;
      cnt            <= '0;
      rsp_valid_p0   <= 1'b0;
      tag_match_p0   <= 1'b0;
      hit_way_p0     <= '0;
      evict_valid_p0 <= 1'b0;
      evict_addr_p0  <= '0;
      flush_done_p0  <= 1'b0;
    end else if (state == ST_INIT) begin
      if (cnt == LINE_BITS'(NUM_SETS - 1)) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else if (!bus.stall) begin
      rsp_valid_p0   <= 1'b0;
      evict_valid_p0 <= 1'b0;
      flush_done_p0  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.flush_req) begin
            state <= ST_FLUSH;
            cnt   <= '0;
          end else if (bus.fill) begin
            rsp_valid_p0   <= 1'b1;
            tag_match_p0   <= 1'b0;
            hit_way_p0     <= vic_way;
            evict_valid_p0 <= vic_entry.valid && vic_entry.dirty;
            evict_addr_p0  <= {vic_entry.tag, req_set};
          end else if (bus.lookup) begin
            rsp_valid_p0 <= 1'b1;
            tag_match_p0 <= lk_hit;
            hit_way_p0   <= lk_way;
          end
        end
        ST_FLUSH: begin
          evict_valid_p0 <= fl_entry.valid && fl_entry.dirty;
          evict_addr_p0  <= {fl_entry.tag, fl_set};
          if (cnt == LINE_BITS'(LINES_PER_BANK - 1)) begin
            state         <= ST_IDLE;
            flush_done_p0 <= 1'b1;
            cnt           <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= ST_INIT;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Storage is not reset; the INIT walk clears it.
  always_ff @(posedge clk) begin
    if (reset) begin
      if (state == ST_INIT) begin
        for (int w = 0; w < NUM_WAYS; w++) entries[init_set][w] <= '0;
        rr_ptr[init_set] <= '0;
      end else if (state == ST_FLUSH && !bus.stall) begin
        entries[fl_set][fl_way].valid <= 1'b0;
        entries[fl_set][fl_way].dirty <= 1'b0;
      end else if (accept_idle) begin
        if (bus.fill) begin
          entries[req_set][vic_way] <= '{valid: 1'b1, dirty: 1'b0, tag: req_tag};
          if (vic_use_ptr)
            rr_ptr[req_set] <= (rr_ptr[req_set] == WAY_BITS'(NUM_WAYS - 1)) ? '0
                                                                             : rr_ptr[req_set] + 1'b1;
        end else if (bus.lookup && bus.write && lk_hit) begin
          entries[req_set][lk_way].dirty <= 1'b1;
        end
      end
    end
  end

  assign bus.ready       = (state == ST_IDLE);
  assign bus.rsp_valid   = rsp_valid_p0;
  assign bus.tag_match   = tag_match_p0;
  assign bus.hit_way     = hit_way_p0;
  assign bus.evict_valid = evict_valid_p0;
  assign bus.evict_addr  = evict_addr_p0;
  assign bus.flush_done  = flush_done_p0;

  // Installing a tag that is already resident would create a duplicate line.
  a_no_dup_fill: assert property (@(posedge clk) disable iff (!reset)
    (accept_idle && bus.fill) |-> !lk_hit);

endmodule

// File: tb/tb_vx_tag_assoc.sv
// Randomized self-checking bench for vx_tag_assoc against a set/way array model.
module tb_vx_tag_assoc;
  import vx_tag_pkg::*;

  typedef logic [LINE_ADDR_WIDTH-1:0] addr_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  vx_tag_assoc_if bus ();

  vx_tag_assoc dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model: what each line holds, plus the per-set replacement pointer.
  bit                  mv [NUM_SETS][NUM_WAYS];
  bit                  md [NUM_SETS][NUM_WAYS];
  logic [TAG_BITS-1:0] mt [NUM_SETS][NUM_WAYS];
  int                  mp [NUM_SETS];
  addr_t               exp_q[$];
  addr_t               live_q[$];

  function automatic addr_t mk_addr(input int tag, input int set);
    return {TAG_BITS'(tag), SET_BITS'(set)};
  endfunction

  function automatic void m_reset();
    for (int s = 0; s < NUM_SETS; s++) begin
      mp[s] = 0;
      for (int w = 0; w < NUM_WAYS; w++) begin
        mv[s][w] = 0; md[s][w] = 0; mt[s][w] = '0;
      end
    end
  endfunction

  function automatic bit m_present(input addr_t a);
    int s = int'(a[SET_BITS-1:0]);
    for (int w = 0; w < NUM_WAYS; w++)
      if (mv[s][w] && mt[s][w] == a[LINE_ADDR_WIDTH-1:SET_BITS]) return 1;
    return 0;
  endfunction

  function automatic void m_lookup(input addr_t a, input bit wr, output bit hit, output int way);
    int s = int'(a[SET_BITS-1:0]);
    hit = 0; way = 0;
    for (int w = 0; w < NUM_WAYS; w++)
      if (!hit && mv[s][w] && mt[s][w] == a[LINE_ADDR_WIDTH-1:SET_BITS]) begin
        hit = 1; way = w;
      end
    if (hit && wr) md[s][way] = 1;
  endfunction

  function automatic void m_fill(input addr_t a, output int way, output bit ev, output addr_t ea);
    int s = int'(a[SET_BITS-1:0]);
    int inv = -1;
    for (int w = 0; w < NUM_WAYS; w++)
      if (inv < 0 && !mv[s][w]) inv = w;
    if (inv >= 0) way = inv;
    else begin
      way   = mp[s];
      mp[s] = (mp[s] + 1) % NUM_WAYS;
    end
    ev = mv[s][way] && md[s][way];
    ea = {mt[s][way], SET_BITS'(s)};
    mv[s][way] = 1; md[s][way] = 0; mt[s][way] = a[LINE_ADDR_WIDTH-1:SET_BITS];
  endfunction

  // Lines in walk order: line n is set n/NUM_WAYS, way n%NUM_WAYS.
  function automatic void m_flush();
    exp_q.delete();
    live_q.delete();
    for (int n = 0; n < LINES_PER_BANK; n++) begin
      int s = n / NUM_WAYS;
      int w = n % NUM_WAYS;
      if (mv[s][w]) live_q.push_back({mt[s][w], SET_BITS'(s)});
      if (mv[s][w] && md[s][w]) exp_q.push_back({mt[s][w], SET_BITS'(s)});
      mv[s][w] = 0; md[s][w] = 0;
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.stall = 0; bus.lookup = 0; bus.write = 0; bus.fill = 0; bus.flush_req = 0; bus.addr = '0;
  endtask

  task automatic do_op(input bit f, input bit lk, input bit wr, input addr_t a);
    bus.fill = f; bus.lookup = lk; bus.write = wr; bus.addr = a;
    step();
    idle_inputs();
  endtask

  task automatic test_reset();
    int n;
    addr_t a;
    idle_inputs();
    reset = 0;
    step(); step();
    n_checks++;
    if ({bus.ready, bus.rsp_valid, bus.tag_match, bus.hit_way, bus.evict_valid, bus.evict_addr, bus.flush_done} !== '0)
      $display("FAIL reset_outputs: got ready=%b rsp=%b match=%b way=%0d ev=%b ea=%h done=%b, want all 0",
               bus.ready, bus.rsp_valid, bus.tag_match, bus.hit_way, bus.evict_valid, bus.evict_addr, bus.flush_done);
    else n_pass++;
    reset = 1;
    m_reset();
    n = 0;
    while (!bus.ready && n < 100) begin n++; step(); end
    n_checks++;
    if (n != NUM_SETS) $display("FAIL init_cycles: got %0d ready-low cycles, want %0d", n, NUM_SETS);
    else n_pass++;
    a = addr_t'($urandom);
    do_op(0, 1, 0, a);
    n_checks++;
    if (bus.rsp_valid !== 1'b1 || bus.tag_match !== 1'b0)
      $display("FAIL post_init_lookup: got rsp=%b match=%b, want 1 0", bus.rsp_valid, bus.tag_match);
    else n_pass++;
  endtask

  task automatic test_fill_basic();
    int ew; bit eev, h; addr_t eea, a;
    for (int i = 0; i < 4; i++) begin
      a = mk_addr(10 + i, 3);
      m_fill(a, ew, eev, eea);
      do_op(1, 0, 0, a);
      n_checks++;
      if (bus.rsp_valid !== 1'b1 || bus.tag_match !== 1'b0 || bus.hit_way !== WAY_BITS'(i) || bus.evict_valid !== 1'b0)
        $display("FAIL fill_basic[%0d]: got rsp=%b match=%b way=%0d ev=%b, want 1 0 %0d 0",
                 i, bus.rsp_valid, bus.tag_match, bus.hit_way, bus.evict_valid, i);
      else n_pass++;
    end
    a = mk_addr(12, 3);
    m_lookup(a, 0, h, ew);
    do_op(0, 1, 0, a);
    n_checks++;
    if (bus.rsp_valid !== 1'b1 || bus.tag_match !== 1'b1 || bus.hit_way !== WAY_BITS'(2))
      $display("FAIL lookup_hit_c: got rsp=%b match=%b way=%0d, want 1 1 2", bus.rsp_valid, bus.tag_match, bus.hit_way);
    else n_pass++;
  endtask

  task automatic test_dirty_evict();
    int ew; bit eev, h; addr_t eea, a;
    a = mk_addr(10, 3);
    m_lookup(a, 1, h, ew);
    do_op(0, 1, 1, a);
    n_checks++;
    if (bus.tag_match !== 1'b1 || bus.hit_way !== WAY_BITS'(0))
      $display("FAIL write_hit_a: got match=%b way=%0d, want 1 0", bus.tag_match, bus.hit_way);
    else n_pass++;
    a = mk_addr(14, 3);
    m_fill(a, ew, eev, eea);
    do_op(1, 0, 0, a);
    n_checks++;
    if (bus.hit_way !== WAY_BITS'(0) || bus.evict_valid !== 1'b1 || bus.evict_addr !== mk_addr(10, 3))
      $display("FAIL fill_evict_dirty: got way=%0d ev=%b ea=%h, want 0 1 %h",
               bus.hit_way, bus.evict_valid, bus.evict_addr, mk_addr(10, 3));
    else n_pass++;
    a = mk_addr(15, 3);
    m_fill(a, ew, eev, eea);
    do_op(1, 0, 0, a);
    n_checks++;
    if (bus.hit_way !== WAY_BITS'(1) || bus.evict_valid !== 1'b0)
      $display("FAIL fill_evict_clean: got way=%0d ev=%b, want 1 0", bus.hit_way, bus.evict_valid);
    else n_pass++;
    // Dirty ways 1 (tag 0xF) and 2 (tag 0xC) of set 3 for the flush scenario.
    for (int i = 0; i < 2; i++) begin
      a = (i == 0) ? mk_addr(15, 3) : mk_addr(12, 3);
      m_lookup(a, 1, h, ew);
      do_op(0, 1, 1, a);
      n_checks++;
      if (bus.tag_match !== 1'b1 || bus.hit_way !== WAY_BITS'(i + 1))
        $display("FAIL mark_dirty[%0d]: got match=%b way=%0d, want 1 %0d", i, bus.tag_match, bus.hit_way, i + 1);
      else n_pass++;
    end
  endtask

  task automatic test_flush_basic();
    addr_t got_q[$];
    int n, done_cnt;
    bit done_last;
    m_flush();
    bus.flush_req = 1; bus.lookup = 1; bus.addr = mk_addr(12, 3);
    step();
    idle_inputs();
    n_checks++;
    if (bus.rsp_valid !== 1'b0 || bus.ready !== 1'b0)
      $display("FAIL flush_priority: got rsp=%b ready=%b, want 0 0", bus.rsp_valid, bus.ready);
    else n_pass++;
    n = 0; done_cnt = 0; done_last = 0;
    while (!bus.ready && n < 200) begin
      step(); n++;
      if (bus.evict_valid) got_q.push_back(bus.evict_addr);
      if (bus.flush_done) done_cnt++;
      done_last = bus.flush_done;
    end
    n_checks++;
    if (n != LINES_PER_BANK) $display("FAIL flush_cycles: got %0d, want %0d", n, LINES_PER_BANK);
    else n_pass++;
    n_checks++;
    if (got_q.size() != 2 || exp_q.size() != 2 || got_q[0] !== mk_addr(15, 3) || got_q[1] !== mk_addr(12, 3))
      $display("FAIL flush_evicts: got %0d evicts first=%h, want 2 evicts %h %h",
               got_q.size(), (got_q.size() > 0) ? got_q[0] : '0, mk_addr(15, 3), mk_addr(12, 3));
    else n_pass++;
    n_checks++;
    if (done_cnt != 1 || !done_last)
      $display("FAIL flush_done: got %0d pulses last=%b, want 1 pulse on last cycle", done_cnt, done_last);
    else n_pass++;
    for (int i = 0; i < live_q.size() && i < 6; i++) begin
      do_op(0, 1, 0, live_q[i]);
      n_checks++;
      if (bus.rsp_valid !== 1'b1 || bus.tag_match !== 1'b0)
        $display("FAIL post_flush_miss[%0d]: got rsp=%b match=%b, want 1 0", i, bus.rsp_valid, bus.tag_match);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    int ew, r;
    bit eev, h, ptm, prv, pev;
    addr_t eea, a, pea;
    logic [WAY_BITS-1:0] pway;
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 9);
      a = mk_addr($urandom_range(0, 5), $urandom_range(0, 3));
      if (r == 0) begin
        prv = bus.rsp_valid; ptm = bus.tag_match; pway = bus.hit_way; pev = bus.evict_valid; pea = bus.evict_addr;
        bus.stall = 1;
        do_op(0, 1, $urandom_range(0, 1), a);
        n_checks++;
        if (bus.rsp_valid !== prv || bus.tag_match !== ptm || bus.hit_way !== pway ||
            bus.evict_valid !== pev || bus.evict_addr !== pea)
          $display("FAIL stall_hold[%0d]: got rsp=%b match=%b way=%0d ev=%b, want held %b %b %0d %b",
                   i, bus.rsp_valid, bus.tag_match, bus.hit_way, bus.evict_valid, prv, ptm, pway, pev);
        else n_pass++;
      end else if (r < 5 && !m_present(a)) begin
        m_fill(a, ew, eev, eea);
        do_op(1, $urandom_range(0, 1), $urandom_range(0, 1), a);
        n_checks++;
        if (bus.rsp_valid !== 1'b1 || bus.tag_match !== 1'b0 || bus.hit_way !== WAY_BITS'(ew) ||
            bus.evict_valid !== eev || (eev && bus.evict_addr !== eea))
          $display("FAIL rand_fill[%0d]: got rsp=%b match=%b way=%0d ev=%b ea=%h, want 1 0 %0d %b %h",
                   i, bus.rsp_valid, bus.tag_match, bus.hit_way, bus.evict_valid, bus.evict_addr, ew, eev, eea);
        else n_pass++;
      end else begin
        r = $urandom_range(0, 1);
        m_lookup(a, r[0], h, ew);
        do_op(0, 1, r[0], a);
        n_checks++;
        if (bus.rsp_valid !== 1'b1 || bus.tag_match !== h || bus.evict_valid !== 1'b0 ||
            (h && bus.hit_way !== WAY_BITS'(ew)))
          $display("FAIL rand_lookup[%0d]: got rsp=%b match=%b way=%0d ev=%b, want 1 %b %0d 0",
                   i, bus.rsp_valid, bus.tag_match, bus.hit_way, bus.evict_valid, h, ew);
        else n_pass++;
      end
    end
  endtask

  task automatic test_flush_stall();
    addr_t got_q[$];
    int n, done_cnt, bad;
    bit st, pev, pdone;
    addr_t pea;
    m_flush();
    bus.flush_req = 1;
    step();
    idle_inputs();
    n = 0; done_cnt = 0;
    while (!bus.ready && n < 200) begin
      st = (n >= 10 && n < 15);
      bus.stall = st;
      pev = bus.evict_valid; pea = bus.evict_addr; pdone = bus.flush_done;
      step(); n++;
      bus.stall = 0;
      if (st) begin
        n_checks++;
        if (bus.evict_valid !== pev || bus.evict_addr !== pea || bus.flush_done !== pdone || bus.ready !== 1'b0)
          $display("FAIL flush_stall_hold[%0d]: got ev=%b ea=%h done=%b ready=%b, want %b %h %b 0",
                   n, bus.evict_valid, bus.evict_addr, bus.flush_done, bus.ready, pev, pea, pdone);
        else n_pass++;
      end else begin
        if (bus.evict_valid) got_q.push_back(bus.evict_addr);
        if (bus.flush_done) done_cnt++;
      end
    end
    n_checks++;
    if (n != LINES_PER_BANK + 5) $display("FAIL flush_stall_cycles: got %0d, want %0d", n, LINES_PER_BANK + 5);
    else n_pass++;
    bad = (got_q.size() != exp_q.size()) ? 1 : 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) bad = 1;
    n_checks++;
    if (bad != 0 || done_cnt != 1)
      $display("FAIL flush_stall_evicts: got %0d evicts %0d done, want %0d evicts 1 done",
               got_q.size(), done_cnt, exp_q.size());
    else n_pass++;
  endtask

  task automatic test_reset_midflush();
    int ew, n, done_cnt;
    bit eev, h;
    addr_t eea, a;
    for (int i = 0; i < 4; i++) begin
      a = mk_addr(20 + i, 5 + i);
      m_fill(a, ew, eev, eea);
      do_op(1, 0, 0, a);
      m_lookup(a, 1, h, ew);
      do_op(0, 1, 1, a);
    end
    for (int s = 0; s < NUM_SETS; s++)
      for (int w = 0; w < NUM_WAYS; w++)
        if (mv[s][w]) live_q.push_back({mt[s][w], SET_BITS'(s)});
    bus.flush_req = 1;
    step();
    idle_inputs();
    done_cnt = 0;
    repeat (20) begin step(); if (bus.flush_done) done_cnt++; end
    reset = 0;
    step();
    n_checks++;
    if ({bus.ready, bus.rsp_valid, bus.evict_valid, bus.flush_done} !== 4'b0)
      $display("FAIL midflush_reset_outputs: got ready=%b rsp=%b ev=%b done=%b, want 0 0 0 0",
               bus.ready, bus.rsp_valid, bus.evict_valid, bus.flush_done);
    else n_pass++;
    reset = 1;
    m_reset();
    n = 0;
    while (!bus.ready && n < 100) begin
      n++; step();
      if (bus.flush_done) done_cnt++;
    end
    n_checks++;
    if (n != NUM_SETS || done_cnt != 0)
      $display("FAIL midflush_reinit: got %0d init cycles %0d done pulses, want %0d 0", n, done_cnt, NUM_SETS);
    else n_pass++;
    for (int i = 0; i < 4 && i < live_q.size(); i++) begin
      do_op(0, 1, 0, live_q[live_q.size() - 1 - i]);
      n_checks++;
      if (bus.rsp_valid !== 1'b1 || bus.tag_match !== 1'b0)
        $display("FAIL midflush_miss[%0d]: got rsp=%b match=%b, want 1 0", i, bus.rsp_valid, bus.tag_match);
      else n_pass++;
    end
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_fill_basic();
    test_dirty_evict();
    test_flush_basic();
    test_random();
    test_flush_stall();
    test_reset_midflush();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
